pat_buf_sched: RTL

//  Scheduler for the shared pattern field-buffer RAM: owns NUM_BUFS buffers of 2**FIELDP_WIDTH bytes,

---
 rtl/pat_buf_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pat_buf_sched.sv
// rtl/pat_buf_sched.sv - pattern field-buffer ownership scheduler and RAM arbiter
// Optional: define PAT_BUF_SCHED_ERR_EN to add the sticky err[3:0] port.
module pat_buf_sched #(
    parameter int NUM_BUFS     = 8,
    parameter int BUFP_WIDTH   = 3,
    parameter int FIELDP_WIDTH = 5,
    parameter int BUFFER_WIDTH = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               host_alloc,
    output logic                               host_alloc_ok,
    output logic [BUFP_WIDTH-1:0]              host_alloc_buf,
    input  logic                               host_commit,
    input  logic                               host_release,
    input  logic                               host_req,
    input  logic                               host_we,
    input  logic [BUFP_WIDTH-1:0]              host_buf,
    input  logic [FIELDP_WIDTH-1:0]            host_field,
    input  logic [BUFFER_WIDTH-1:0]            host_wdata,
    output logic                               host_gnt,
    input  logic                               pat_claim,
    output logic                               pat_claim_ok,
    output logic [BUFP_WIDTH-1:0]              pat_bufp,
    output logic                               pat_busy,
    input  logic                               pat_done,
    input  logic                               pat_req,
    input  logic                               pat_we,
    input  logic [FIELDP_WIDTH-1:0]            pat_fieldp,
    input  logic [FIELDP_WIDTH-1:0]            pat_fieldwp,
    input  logic [BUFFER_WIDTH-1:0]            pat_wdata,
    output logic                               pat_gnt,
    output logic [BUFFER_WIDTH-1:0]            rdata,
    output logic                               host_rvalid,
    output logic                               pat_rvalid,
    output logic                               ram_en,
    output logic                               ram_we,
    output logic [BUFP_WIDTH+FIELDP_WIDTH-1:0] ram_adr,
    output logic [BUFFER_WIDTH-1:0]            ram_wdata,
    input  logic [BUFFER_WIDTH-1:0]            ram_rdata
`ifdef PAT_BUF_SCHED_ERR_EN
    ,
    output logic [3:0]                         err
`endif
);

    localparam int CNT_W = BUFP_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_HOST  = 2'd1,
        ST_READY = 2'd2,
        ST_PAT   = 2'd3
    } buf_state_t;

    buf_state_t              r_state [NUM_BUFS];
    logic [BUFP_WIDTH-1:0]   r_q [NUM_BUFS];
    logic [BUFP_WIDTH-1:0]   r_head;
    logic [BUFP_WIDTH-1:0]   r_tail;
    logic [CNT_W-1:0]        r_count;
    logic                    r_pat_busy;
    logic [BUFP_WIDTH-1:0]   r_pat_bufp;
    logic                    r_rr_pat;
    logic                    r_host_rd;
    logic                    r_pat_rd;

    logic                    w_free_found;
    logic [BUFP_WIDTH-1:0]   w_free_idx;
    logic                    w_host_owns;
    logic                    w_commit;
    logic                    w_release;
    logic                    w_claim;
    logic                    w_done;
    logic                    w_host_legal;
    logic                    w_pat_legal;
    logic                    w_host_gnt;
    logic                    w_pat_gnt;
    logic [FIELDP_WIDTH-1:0] w_pat_field;
    logic [CNT_W-1:0]        w_push;
    logic [CNT_W-1:0]        w_pop;

    // Scan downwards so the last hit is the lowest free index.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = BUFP_WIDTH'(i);
            end
        end
    end

    assign w_host_owns  = (r_state[host_buf] == ST_HOST);
    assign w_commit     = !reset && host_commit && w_host_owns;
    assign w_release    = !reset && host_release && w_host_owns && !host_commit;
    assign w_claim      = !reset && pat_claim && (r_count != '0) && !r_pat_busy;
    assign w_done       = !reset && pat_done && r_pat_busy;
    assign w_host_legal = !reset && host_req && w_host_owns;
    assign w_pat_legal  = !reset && pat_req && r_pat_busy;
    assign w_pat_field  = pat_we ? pat_fieldwp : pat_fieldp;
    assign w_push       = {{(CNT_W-1){1'b0}}, w_commit};
    assign w_pop        = {{(CNT_W-1){1'b0}}, w_claim};

    always_comb begin
        w_host_gnt = w_host_legal;
        w_pat_gnt  = w_pat_legal;
        if (w_host_legal && w_pat_legal) begin
            w_host_gnt = !r_rr_pat;
            w_pat_gnt  = r_rr_pat;
        end
    end

    assign host_alloc_ok  = !reset && host_alloc && w_free_found;
    assign host_alloc_buf = w_free_idx;
    assign host_gnt       = w_host_gnt;
    assign pat_gnt        = w_pat_gnt;
    assign pat_claim_ok   = w_claim;
    assign pat_bufp       = r_pat_bufp;
    assign pat_busy       = r_pat_busy;
    assign ram_en         = w_host_gnt || w_pat_gnt;
    assign ram_we         = w_host_gnt ? host_we : (w_pat_gnt && pat_we);
    assign ram_adr        = w_host_gnt ? {host_buf, host_field} : {r_pat_bufp, w_pat_field};
    assign ram_wdata      = w_host_gnt ? host_wdata : pat_wdata;
    assign rdata          = ram_rdata;
    assign host_rvalid    = r_host_rd;
    assign pat_rvalid     = r_pat_rd;

    // Alloc, commit/release, claim and done always address distinct buffers
    // (FREE, HOST, READY and PAT respectively), so the updates never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BUFS; i++) begin
                r_state[i] <= ST_FREE;
            end
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_pat_busy <= 1'b0;
            r_pat_bufp <= '0;
            r_rr_pat   <= 1'b0;
            r_host_rd  <= 1'b0;
            r_pat_rd   <= 1'b0;
        end else begin
            if (host_alloc_ok) begin
                r_state[w_free_idx] <= ST_HOST;
            end
            if (w_commit) begin
                r_state[host_buf] <= ST_READY;
                r_q[r_tail]       <= host_buf;
                r_tail            <= r_tail + 1'b1;
            end else if (w_release) begin
                r_state[host_buf] <= ST_FREE;
            end
            if (w_claim) begin
                r_state[r_q[r_head]] <= ST_PAT;
                r_pat_bufp           <= r_q[r_head];
                r_pat_busy           <= 1'b1;
                r_head               <= r_head + 1'b1;
            end
            if (w_done) begin
                r_state[r_pat_bufp] <= ST_HOST;
                r_pat_busy          <= 1'b0;
            end
            r_count <= r_count + w_push - w_pop;
            if (w_host_gnt) begin
                r_rr_pat <= 1'b1;
            end else if (w_pat_gnt) begin
                r_rr_pat <= 1'b0;
            end
            r_host_rd <= w_host_gnt && !host_we;
            r_pat_rd  <= w_pat_gnt && !pat_we;
        end
    end

`ifdef PAT_BUF_SCHED_ERR_EN
    logic [3:0] r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else begin
            r_err <= r_err | {(pat_claim && r_pat_busy) || (pat_done && !r_pat_busy),
                              (host_commit || host_release) && !w_host_owns,
                              pat_req && !r_pat_busy,
                              host_req && !w_host_owns};
        end
    end

    assign err = r_err;
`endif

endmodule
